quad_encoder_gen: RTL and testbench

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

---
 rtl/quad_encoder_gen_pkg.sv | 26 ++
 rtl/quad_encoder_gen_us_strobe_gen.sv | 27 ++
 rtl/quad_encoder_gen.sv | 100 ++++++++++
 tb/tb_quad_encoder_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// Shared quadrature encoder definitions, used by both the generator and the decoder.
package quad_encoder_gen_pkg;

  localparam logic [31:0] QUAD_STOP_TIME = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_state_t;

  // Forward walks 00->10->11->01->00; reverse walks the same ring backwards.
  function automatic quad_state_t quad_next(input quad_state_t cur, input logic forward);
    quad_state_t nxt;
    case (cur)
      Q00:     nxt = forward ? Q10 : Q01;
      Q10:     nxt = forward ? Q11 : Q00;
      Q11:     nxt = forward ? Q01 : Q10;
      Q01:     nxt = forward ? Q00 : Q11;
      default: nxt = Q00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_us_strobe_gen.sv
// Free-running microsecond prescaler: one-cycle strobe every TICKS_PER_MICROSECOND clocks.
module us_strobe_gen #(
  parameter int TICKS_PER_MICROSECOND = 50
) (
  input  logic clk,
  input  logic reset,
  output logic us_strobe
);

  localparam int CW = (TICKS_PER_MICROSECOND > 1) ? $clog2(TICKS_PER_MICROSECOND) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MICROSECOND - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign us_strobe = (count == LAST);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator: emits A/B edges at a commanded microsecond period
// and direction, tracking the signed edge count.
module quad_encoder_gen
  import quad_encoder_gen_pkg::*;
#(
  parameter int          TICKS_PER_MICROSECOND = 50,
  parameter logic [31:0] STOP_TIME             = QUAD_STOP_TIME
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_time_per_tick,
  input  logic        cmd_sign,
  output logic        enc_a,
  output logic        enc_b,
  output logic        state_change,
  output logic [31:0] position
);

  logic        us_strobe;
  logic        pending_valid;
  logic [31:0] pending_period;
  logic        pending_sign;
  logic [31:0] active_period;
  logic        active_sign;
  logic [31:0] elapsed;
  quad_state_t quad;
  quad_state_t quad_nxt;
  logic [31:0] position_nxt;
  logic        running;
  logic        edge_due;
  logic        cmd_accept;
  logic        apply_now;

  us_strobe_gen #(
    .TICKS_PER_MICROSECOND(TICKS_PER_MICROSECOND)
  ) u_us_strobe_gen (
    .clk      (clk),
    .reset    (reset),
    .us_strobe(us_strobe)
  );

  assign running    = (active_period != 32'd0) && (active_period != STOP_TIME);
  assign edge_due   = running && us_strobe && (elapsed == active_period - 32'd1);
  assign cmd_accept = cmd_valid && !pending_valid;
  // While running, a new command only takes over on an edge so intervals never mix periods.
  assign apply_now  = pending_valid && (!running || edge_due);

  assign cmd_ready = !pending_valid;
  assign enc_a     = quad[1];
  assign enc_b     = quad[0];

  always_comb begin
    quad_nxt     = quad_next(quad, active_sign);
    position_nxt = active_sign ? position + 32'd1 : position - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_valid  <= 1'b0;
      pending_period <= '0;
      pending_sign   <= 1'b1;
    end else if (cmd_accept) begin
      pending_valid  <= 1'b1;
      pending_period <= cmd_time_per_tick;
      pending_sign   <= cmd_sign;
    end else if (apply_now) begin
      pending_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_period <= STOP_TIME;
      active_sign   <= 1'b1;
      elapsed       <= '0;
      quad          <= Q00;
      position      <= '0;
      state_change  <= 1'b0;
    end else begin
      state_change <= 1'b0;
      if (apply_now) begin
        active_period <= pending_period;
        active_sign   <= pending_sign;
      end
      if (edge_due) begin
        quad         <= quad_nxt;
        position     <= position_nxt;
        state_change <= 1'b1;
        elapsed      <= '0;
      end else if (apply_now) begin
        elapsed <= '0;
      end else if (running && us_strobe) begin
        elapsed <= elapsed + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed self-checking bench for quad_encoder_gen with the default 50-tick microsecond.
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_time_per_tick = '0;
  logic        cmd_sign = 1'b1;
  logic        enc_a;
  logic        enc_b;
  logic        state_change;
  logic [31:0] position;

  int tests = 0;
  int fails = 0;

  quad_encoder_gen dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_time_per_tick(cmd_time_per_tick),
    .cmd_sign         (cmd_sign),
    .enc_a            (enc_a),
    .enc_b            (enc_b),
    .state_change     (state_change),
    .position         (position)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offers one command for a single cycle; called and returns on a falling edge.
  task automatic apply_stimulus(input logic [31:0] period, input logic sign);
    cmd_valid         = 1'b1;
    cmd_time_per_tick = period;
    cmd_sign          = sign;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_change(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!state_change && cycles < budget);
  endtask

  function automatic logic [31:0] ab();
    return {30'b0, enc_a, enc_b};
  endfunction

  initial begin
    int c;
    int pulses;
    logic [31:0] held_ab;
    logic [31:0] held_pos;
    logic [1:0]  fwd_ab  [4];
    logic [1:0]  rev_ab  [6];
    logic [31:0] rev_pos [6];

    fwd_ab  = '{2'b10, 2'b11, 2'b01, 2'b00};
    rev_ab  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    rev_pos = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_output("reset_ab", ab(), 32'd0);
    check_output("reset_pos", position, 32'd0);
    check_output("reset_sc", {31'b0, state_change}, 32'd0);
    check_output("reset_ready", {31'b0, cmd_ready}, 32'd1);

    // Period 3 forward: four edges, 150 clocks apart.
    apply_stimulus(32'd3, 1'b1);
    wait_change(400, c);
    check_output("fwd_first_sc", {31'b0, state_change}, 32'd1);
    check_output("fwd_first_ab", ab(), {30'b0, fwd_ab[0]});
    check_output("fwd_first_pos", position, 32'd1);
    for (int i = 1; i < 4; i++) begin
      wait_change(400, c);
      check_output("fwd_interval", c, 32'd150);
      check_output("fwd_ab", ab(), {30'b0, fwd_ab[i]});
      check_output("fwd_pos", position, 32'(i + 1));
    end

    // Period 1 offered mid-interval: current interval still completes at 150.
    repeat (40) @(negedge clk);
    apply_stimulus(32'd1, 1'b1);
    check_output("mid_ready_low", {31'b0, cmd_ready}, 32'd0);
    repeat (50) @(negedge clk);
    check_output("mid_ready_still_low", {31'b0, cmd_ready}, 32'd0);
    wait_change(400, c);
    check_output("mid_interval", 41 + 50 + c, 32'd150);
    check_output("mid_ab", ab(), 32'b10);
    check_output("mid_pos", position, 32'd5);
    check_output("mid_ready_freed", {31'b0, cmd_ready}, 32'd1);

    // Reverse queued now, applied on the edge that lands on 11; next edge steps back to 10.
    apply_stimulus(32'd1, 1'b0);
    wait_change(400, c);
    check_output("p1_interval", 1 + c, 32'd50);
    check_output("p1_ab", ab(), 32'b11);
    check_output("p1_pos", position, 32'd6);
    wait_change(400, c);
    check_output("rev_interval", c, 32'd50);
    check_output("rev_ab", ab(), 32'b10);
    check_output("rev_pos", position, 32'd5);

    for (int i = 0; i < 6; i++) begin
      wait_change(400, c);
      check_output("rev_walk_interval", c, 32'd50);
      check_output("rev_walk_ab", ab(), {30'b0, rev_ab[i]});
      check_output("rev_walk_pos", position, rev_pos[i]);
    end

    // Forward queued at FFFFFFFF: one more reverse edge, then forward wraps back to 0.
    apply_stimulus(32'd1, 1'b1);
    wait_change(400, c);
    check_output("wrap_rev_ab", ab(), 32'b11);
    check_output("wrap_rev_pos", position, 32'hFFFF_FFFE);
    wait_change(400, c);
    check_output("wrap_fwd1_ab", ab(), 32'b01);
    check_output("wrap_fwd1_pos", position, 32'hFFFF_FFFF);
    wait_change(400, c);
    check_output("wrap_fwd2_ab", ab(), 32'b00);
    check_output("wrap_fwd2_pos", position, 32'd0);

    // Period 0 then STOP_TIME: nothing moves.
    apply_stimulus(32'd0, 1'b1);
    wait_change(400, c);
    check_output("stop_last_interval", 1 + c, 32'd50);
    check_output("stop_last_ab", ab(), 32'b10);
    check_output("stop_last_pos", position, 32'd1);
    apply_stimulus(32'hFFFF_FFFF, 1'b1);
    check_output("stop_ready_low", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    check_output("stop_ready_high", {31'b0, cmd_ready}, 32'd1);
    held_ab  = ab();
    held_pos = position;
    pulses   = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (state_change) pulses++;
    end
    check_output("stop_no_pulses", pulses, 32'd0);
    check_output("stop_ab_held", ab(), 32'b10);
    check_output("stop_pos_held", position, 32'd1);
    check_output("stop_pos_snapshot", position, held_pos);
    check_output("stop_ab_snapshot", ab(), held_ab);

    // Reset two clocks before a due edge with a command pending.
    apply_stimulus(32'd3, 1'b1);
    wait_change(400, c);
    check_output("pre_reset_ab", ab(), 32'b11);
    check_output("pre_reset_pos", position, 32'd2);
    apply_stimulus(32'd5, 1'b0);
    check_output("pre_reset_pending", {31'b0, cmd_ready}, 32'd0);
    repeat (146) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("mid_reset_ab", ab(), 32'd0);
    check_output("mid_reset_pos", position, 32'd0);
    check_output("mid_reset_sc", {31'b0, state_change}, 32'd0);
    check_output("mid_reset_ready", {31'b0, cmd_ready}, 32'd1);
    wait_change(400, c);
    check_output("post_reset_no_edge", {31'b0, state_change}, 32'd0);
    check_output("post_reset_pos", position, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
